// File: rtl/sdcard_cmd_seq_if.sv
// rtl/sdcard_cmd_seq_if.sv - MMIO bus between the command sequencer and the SD byte engine
interface sdcard_cmd_seq_if;
    logic [3:0]  m_adr;
    logic        m_cs;
    logic [0:3]  m_sel;
    logic        m_we;
    logic [0:31] m_d;
    logic [0:31] m_q;

    modport master (output m_adr, m_cs, m_sel, m_we, m_d, input m_q);
    modport slave  (input m_adr, m_cs, m_sel, m_we, m_d, output m_q);
endinterface

// File: rtl/sdcard_cmd_seq.sv
// rtl/sdcard_cmd_seq.sv - SD command/response/single-block-read sequencer driving the SPI byte engine
module sdcard_cmd_seq #(
    parameter int NCR_MAX   = 8,
    parameter int TOKEN_MAX = 4096,
    parameter int BLOCK_LEN = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [5:0]       cmd_index,
    input  logic [0:31]      cmd_arg,
    input  logic             data_read,
    output logic             busy,
    output logic             done,
    output logic [2:0]       status,
    output logic [7:0]       r1,
    output logic             data_valid,
    output logic [7:0]       data_byte,
    sdcard_cmd_seq_if.master eng
);
    localparam int CMAX = (TOKEN_MAX > BLOCK_LEN)
                        ? ((TOKEN_MAX > NCR_MAX) ? TOKEN_MAX : NCR_MAX)
                        : ((BLOCK_LEN > NCR_MAX) ? BLOCK_LEN : NCR_MAX);
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] NCR_LAST = CW'(NCR_MAX - 1);
    localparam logic [CW-1:0] TOK_LAST = CW'(TOKEN_MAX - 1);
    localparam logic [CW-1:0] BLK_LAST = CW'(BLOCK_LEN - 1);

    localparam logic [2:0] ST_OK = 3'd0, ST_NORESP = 3'd1, ST_R1ERR = 3'd2, ST_TOKTO = 3'd3;
    localparam logic [2:0] ST_DERR = 3'd4, ST_CRCERR = 3'd5, ST_ABORT = 3'd6;

    typedef enum logic [3:0] {
        S_IDLE, S_CSON, S_CMD, S_CRC_RD, S_CRC_TX, S_RESP, S_TOKEN,
        S_CLR, S_DATA, S_CRC16, S_CRC16_RD, S_END_X, S_END_OFF
    } state_t;
    typedef enum logic [1:0] {X_WR, X_SKIP, X_POLL} xph_t;

    state_t        state, state_n;
    xph_t          xph;
    logic [CW-1:0] cnt;
    logic [5:0]    idx_r;
    logic [0:31]   arg_r;
    logic          rd_r;
    logic [7:0]    crc_r;
    logic          abort_pend;
    logic          st_load;
    logic [2:0]    st_val;
    logic [7:0]    tx;
    logic [7:0]    rx;
    logic          in_xfer, xfer_done, accept, abort_zone, aborting;
    logic          unused_q;

    assign rx         = eng.m_q[24:31];
    assign unused_q   = ^eng.m_q[8:15];
    assign in_xfer    = state inside {S_CMD, S_CRC_TX, S_RESP, S_TOKEN, S_DATA, S_CRC16, S_END_X};
    // Engine busy flag is only looked at in the poll phase; the skip cycle covers its register delay.
    assign xfer_done  = in_xfer && (xph == X_POLL) && !eng.m_q[23];
    assign accept     = (state == S_IDLE) && start && !done;
    assign abort_zone = !(state inside {S_IDLE, S_END_X, S_END_OFF});
    assign aborting   = abort_zone && (abort || abort_pend);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            xph        <= X_WR;
            cnt        <= '0;
            idx_r      <= '0;
            arg_r      <= '0;
            rd_r       <= 1'b0;
            crc_r      <= '0;
            abort_pend <= 1'b0;
            status     <= '0;
            r1         <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state <= state_n;
            if (!in_xfer || xfer_done)  xph <= X_WR;
            else if (xph == X_WR)       xph <= X_SKIP;
            else                        xph <= X_POLL;
            if (state_n != state)       cnt <= '0;
            else if (xfer_done)         cnt <= cnt + 1'b1;
            if (accept) begin
                idx_r      <= cmd_index;
                arg_r      <= cmd_arg;
                rd_r       <= data_read;
                status     <= ST_OK;
                r1         <= '0;
                abort_pend <= 1'b0;
                busy       <= 1'b1;
            end else begin
                if (abort_zone && abort) abort_pend <= 1'b1;
                if (st_load)             status <= st_val;
                if (state == S_RESP && xfer_done && !rx[7]) r1 <= rx;
                if (state == S_CRC_RD)   crc_r <= eng.m_q[0:7];
                if (state == S_END_OFF)  busy <= 1'b0;
            end
            done <= (state == S_END_OFF);
        end
    end

    always_comb begin
        state_n = state;
        st_load = 1'b0;
        st_val  = ST_OK;
        case (state)
            S_IDLE:     if (accept) state_n = S_CSON;
            S_CSON:     state_n = S_CMD;
            S_CMD:      if (xfer_done && cnt[2:0] == 3'd4) state_n = S_CRC_RD;
            S_CRC_RD:   state_n = S_CRC_TX;
            S_CRC_TX:   if (xfer_done) state_n = S_RESP;
            S_RESP: if (xfer_done) begin
                if (!rx[7]) begin
                    if (!rd_r) begin
                        state_n = S_END_X; st_load = 1'b1; st_val = ST_OK;
                    end else if (rx != 8'h00) begin
                        state_n = S_END_X; st_load = 1'b1; st_val = ST_R1ERR;
                    end else begin
                        state_n = S_TOKEN;
                    end
                end else if (cnt == NCR_LAST) begin
                    state_n = S_END_X; st_load = 1'b1; st_val = ST_NORESP;
                end
            end
            S_TOKEN: if (xfer_done) begin
                if (rx == 8'hFE) begin
                    state_n = S_CLR;
                end else if (rx[7:4] == 4'h0) begin
                    state_n = S_END_X; st_load = 1'b1; st_val = ST_DERR;
                end else if (cnt == TOK_LAST) begin
                    state_n = S_END_X; st_load = 1'b1; st_val = ST_TOKTO;
                end
            end
            S_CLR:      state_n = S_DATA;
            S_DATA:     if (xfer_done && cnt == BLK_LAST) state_n = S_CRC16;
            S_CRC16:    if (xfer_done && cnt == CW'(1)) state_n = S_CRC16_RD;
            S_CRC16_RD: begin
                state_n = S_END_X;
                st_load = 1'b1;
                st_val  = (eng.m_q[16:31] != 16'h0) ? ST_CRCERR : ST_OK;
            end
            S_END_X:    if (xfer_done) state_n = S_END_OFF;
            S_END_OFF:  state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
        // Abort only takes effect at a step boundary so an engine transfer is never cut short.
        if (aborting && (in_xfer ? xfer_done : 1'b1)) begin
            state_n = S_END_X;
            st_load = 1'b1;
            st_val  = ST_ABORT;
        end
    end

    always_comb begin
        tx = 8'hFF;
        if (state == S_CMD) begin
            case (cnt[2:0])
                3'd1:    tx = arg_r[0:7];
                3'd2:    tx = arg_r[8:15];
                3'd3:    tx = arg_r[16:23];
                3'd4:    tx = arg_r[24:31];
                default: tx = {2'b01, idx_r};
            endcase
        end else if (state == S_CRC_TX) begin
            tx = crc_r;
        end

        eng.m_adr = 4'd0;
        eng.m_cs  = 1'b0;
        eng.m_sel = 4'b0000;
        eng.m_we  = 1'b0;
        eng.m_d   = '0;
        if (in_xfer && xph == X_WR) begin
            eng.m_cs       = 1'b1;
            eng.m_we       = 1'b1;
            eng.m_sel      = 4'b0011;
            eng.m_d[19]    = 1'b1;
            eng.m_d[23]    = 1'b1;
            eng.m_d[24:31] = tx;
        end
        case (state)
            S_CSON: begin
                eng.m_cs = 1'b1; eng.m_we = 1'b1; eng.m_sel = 4'b0010; eng.m_d[19] = 1'b1;
            end
            S_CRC_RD, S_CRC16_RD: eng.m_adr = 4'd1;
            S_CLR: begin
                eng.m_adr = 4'd1; eng.m_cs = 1'b1; eng.m_we = 1'b1; eng.m_sel = 4'b0011;
            end
            S_END_OFF: begin
                eng.m_cs = 1'b1; eng.m_we = 1'b1; eng.m_sel = 4'b0010;
            end
            default: ;
        endcase

        data_valid = (state == S_DATA) && xfer_done && !aborting;
        data_byte  = data_valid ? rx : 8'h00;
    end
endmodule
